// File: rtl/timer_pkg.sv
// Shared constants and width helper for the millisecond countdown timer.
package timer_pkg;

  // Default clocking: 50 MHz system clock gives 50000 cycles per ms.
  localparam int unsigned CLKS_PER_MS_50MHZ = 50000;

  // Largest loadable count in ms at the default build.
  localparam int unsigned MAX_MS_DEFAULT = 2047;

  // Counter width needed to hold 0..max_ms.
  function automatic int unsigned cnt_width(input int unsigned max_ms);
    cnt_width = $clog2(max_ms + 1);
  endfunction

endpackage : timer_pkg

// File: rtl/ms_tick_gen.sv
// Prescaler that turns CLKS_PER_MS enabled clock cycles into one ms tick.
// The tick is asserted during the cycle whose rising edge wraps the
// prescaler, so the consumer acts on the same edge as the wrap.
module ms_tick_gen
  import timer_pkg::*;
#(
  parameter int unsigned CLKS_PER_MS = CLKS_PER_MS_50MHZ
) (
  input  logic clk,
  input  logic stop,
  input  logic enable,
  output logic tick
);

  localparam int unsigned PW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLKS_PER_MS - 1);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;
  logic          at_last;

  // Next prescaler value: clear on stop, hold while paused, wrap at LAST.
  always_comb begin
    cnt_d   = cnt_q;
    at_last = (cnt_q == LAST);
    tick    = 1'b0;
    if (stop) begin
      cnt_d = '0;
    end else if (enable) begin
      tick = at_last;
      if (at_last) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + PW'(1);
      end
    end
  end

  // Prescaler register; stop acts as a synchronous clear.
  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

endmodule : ms_tick_gen

// File: rtl/timer.sv
// Millisecond countdown timer: loads on stop, counts down once per ms
// while enabled, and raises a sticky game_over when the count hits zero.
module timer
  import timer_pkg::*;
#(
  parameter  int unsigned MAX_MS      = MAX_MS_DEFAULT,
  parameter  int unsigned CLKS_PER_MS = CLKS_PER_MS_50MHZ,
  localparam int unsigned W           = cnt_width(MAX_MS)
) (
  input  logic         clk,
  input  logic         stop,
  input  logic [W-1:0] start_value,
  input  logic         enable,
  output logic [W-1:0] timer_value,
  output logic         game_over
);

  // A clamp is only needed when the port can express values above MAX_MS.
  localparam longint unsigned PORT_MAX   = (longint'(1) << W) - 1;
  localparam bit              NEED_CLAMP = (longint'(MAX_MS) != PORT_MAX);

  logic         tick;
  logic [W-1:0] load_val;
  logic [W-1:0] value_q;
  logic [W-1:0] value_d;
  logic         over_q;
  logic         over_d;

  ms_tick_gen #(
    .CLKS_PER_MS (CLKS_PER_MS)
  ) u_tick (
    .clk    (clk),
    .stop   (stop),
    .enable (enable),
    .tick   (tick)
  );

  generate
    if (NEED_CLAMP) begin : g_clamp
      // Saturate oversized loads to MAX_MS.
      always_comb begin
        load_val = start_value;
        if (start_value > W'(MAX_MS)) begin
          load_val = W'(MAX_MS);
        end
      end
    end else begin : g_no_clamp
      assign load_val = start_value;
    end
  endgenerate

  // Next count and expiry flag; stop wins over ticks and expiry.
  always_comb begin
    value_d = value_q;
    over_d  = over_q;
    if (stop) begin
      value_d = load_val;
      over_d  = 1'b0;
    end else begin
      if (tick && (value_q != '0)) begin
        value_d = value_q - W'(1);
      end
      if (value_d == '0) begin
        over_d = 1'b1;
      end
    end
  end

  // Count and flag registers drive the outputs directly.
  always_ff @(posedge clk) begin
    value_q <= value_d;
    over_q  <= over_d;
  end

  assign timer_value = value_q;
  assign game_over   = over_q;

endmodule : timer

// File: tb/tb_timer.sv
// Bench for timer: directed vector table from the test plan, then random
// stop/enable/start_value traffic checked against an arithmetic model.
module tb_timer;

  localparam int unsigned CPM    = 10;
  localparam int unsigned MAXMS  = 2047;
  localparam int unsigned W      = 11;

  logic         clk;
  logic         stop;
  logic [W-1:0] start_value;
  logic         enable;
  logic [W-1:0] timer_value;
  logic         game_over;

  int n_vec;
  int n_bad;

  // Model: the value is the loaded count minus whole ms of enabled time.
  int unsigned m_start;
  int unsigned m_en_cycles;
  bit          m_go;

  typedef struct {
    logic         stop;
    logic         en;
    logic [W-1:0] sv;
    int           n;
    logic [W-1:0] exp_v;
    logic         exp_go;
  } vec_t;

  vec_t tbl[$];

  timer #(
    .MAX_MS      (MAXMS),
    .CLKS_PER_MS (CPM)
  ) dut (
    .clk         (clk),
    .stop        (stop),
    .start_value (start_value),
    .enable      (enable),
    .timer_value (timer_value),
    .game_over   (game_over)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic int unsigned model_value();
    int unsigned ms;
    ms = m_en_cycles / CPM;
    return (m_start > ms) ? (m_start - ms) : 0;
  endfunction

  task automatic add(input logic s, input logic e, input int sv, input int n,
                     input int ev, input logic eg);
    vec_t v;
    v.stop = s; v.en = e; v.sv = W'(sv); v.n = n; v.exp_v = W'(ev); v.exp_go = eg;
    tbl.push_back(v);
  endtask

  // Drive one cycle, advance the model, and compare against it.
  task automatic step(input logic s, input logic e, input logic [W-1:0] sv);
    int unsigned mv;
    stop = s; enable = e; start_value = sv;
    @(posedge clk);
    #1;
    if (s) begin
      m_start     = (int'(sv) > int'(MAXMS)) ? MAXMS : int'(sv);
      m_en_cycles = 0;
      m_go        = 1'b0;
    end else begin
      if (e) m_en_cycles++;
      if (model_value() == 0) m_go = 1'b1;
    end
    mv = model_value();
    n_vec++;
    if (timer_value !== W'(mv) || game_over !== m_go) begin
      n_bad++;
      $display("FAIL model t=%0t: timer_value=%0d game_over=%0b, expected %0d/%0b",
               $time, timer_value, game_over, mv, m_go);
    end
  endtask

  initial begin
    n_vec = 0; n_bad = 0;
    m_start = 0; m_en_cycles = 0; m_go = 1'b0;
    stop = 1'b1; enable = 1'b0; start_value = '0;

    // Count 5 down to 0, first decrement at enabled cycle 10.
    add(1, 0, 5, 2, 5, 0);
    add(0, 1, 5, 9, 5, 0);
    add(0, 1, 5, 1, 4, 0);
    add(0, 1, 5, 10, 3, 0);
    add(0, 1, 5, 10, 2, 0);
    add(0, 1, 5, 10, 1, 0);
    add(0, 1, 5, 9, 1, 0);
    add(0, 1, 5, 1, 0, 1);
    // Ticks after expiry must not underflow.
    add(0, 1, 5, 25, 0, 1);
    // Reload after expiry, pause keeps the partial ms.
    add(1, 0, 5, 2, 5, 0);
    add(0, 1, 5, 13, 4, 0);
    add(0, 0, 5, 5, 4, 0);
    add(0, 1, 5, 6, 4, 0);
    add(0, 1, 5, 1, 3, 0);
    // Mid-count stop discards the prescaler phase.
    add(0, 1, 5, 5, 3, 0);
    add(1, 1, 5, 1, 5, 0);
    add(0, 1, 5, 9, 5, 0);
    add(0, 1, 5, 1, 4, 0);
    // Full 50 enabled cycles to expiry after a fresh load.
    add(1, 0, 5, 2, 5, 0);
    add(0, 1, 5, 49, 1, 0);
    add(0, 1, 5, 1, 0, 1);
    // Zero load expires one edge after release even when disabled.
    add(1, 0, 0, 2, 0, 0);
    add(0, 0, 0, 1, 0, 1);
    add(0, 0, 0, 3, 0, 1);
    // Maximum load.
    add(1, 0, 2047, 1, 2047, 0);
    add(0, 1, 2047, 9, 2047, 0);
    add(0, 1, 2047, 1, 2046, 0);

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) step(tbl[i].stop, tbl[i].en, tbl[i].sv);
      n_vec++;
      if (timer_value !== tbl[i].exp_v || game_over !== tbl[i].exp_go) begin
        n_bad++;
        $display("FAIL vec%0d: timer_value=%0d game_over=%0b, expected %0d/%0b",
                 i, timer_value, game_over, tbl[i].exp_v, tbl[i].exp_go);
      end
    end

    // Hand sequence: value must hold exactly until the 10th enabled cycle.
    step(1'b1, 1'b0, W'(3));
    for (int k = 1; k <= CPM; k++) begin
      step(1'b0, 1'b1, W'(3));
      n_vec++;
      if (timer_value !== ((k == int'(CPM)) ? W'(2) : W'(3))) begin
        n_bad++;
        $display("FAIL latency k=%0d: timer_value=%0d", k, timer_value);
      end
    end

    // Random traffic; small loads so expiry happens often.
    for (int c = 0; c < 4000; c++) begin
      logic         s;
      logic         e;
      logic [W-1:0] sv;
      s  = ($urandom_range(0, 79) == 0);
      e  = ($urandom_range(0, 3) != 0);
      sv = ($urandom_range(0, 7) == 0) ? W'($urandom) : W'($urandom_range(0, 12));
      step(s, e, sv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_timer
